udp_tx_arbiter: RTL
===================

// Module: udp_tx_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single UDP TX user interface (header + 8-bit payload) of the
//  udp_top stack between NUM_PORTS independent requesters. Grants one complete frame at a time:
//  forwards the winner's header, then its payload up to tlast, then re-arbitrates. Sits between user
//  logic and udp_top's udp_tx_* ports, all in the axis_clk domain.
// PARAMETERS
//  NUM_PORTS  4   number of requesters, 2..8
//  IDX_W      2   grant index width, must equal clog2(NUM_PORTS)
// PORTS
//  axis_clk          in   1             single clock
//  axis_rstn         in   1             async active-low reset
//  s_hdr_valid       in   NUM_PORTS     per-port header valid
//  s_hdr_ready       out  NUM_PORTS     per-port header ready
//  s_dest_ip         in   NUM_PORTS*32  per-port dest IP; port p at [p*32+:32]
//  s_src_port        in   NUM_PORTS*16  per-port UDP source port
//  s_dest_port       in   NUM_PORTS*16  per-port UDP dest port
//  s_tdata           in   NUM_PORTS*8   per-port payload byte
//  s_tvalid          in   NUM_PORTS     per-port payload valid
//  s_tready          out  NUM_PORTS     per-port payload ready
//  s_tlast           in   NUM_PORTS     per-port payload last
//  m_hdr_valid       out  1             to udp_tx_hdr_valid
//  m_hdr_ready       in   1             from udp_tx_hdr_ready
//  m_dest_ip         out  32            to udp_tx_dest_ip
//  m_src_port        out  16            to udp_tx_src_port
//  m_dest_port       out  16            to udp_tx_dest_port
//  m_tdata           out  8             to udp_tx_tdata
//  m_tvalid          out  1             to udp_tx_tvalid
//  m_tready          in   1             from udp_tx_tready
//  m_tlast           out  1             to udp_tx_tlast
//  grant_idx         out  IDX_W         port currently owning the interface (valid when busy=1)
//  busy              out  1             1 in HDR or PAYLOAD state
// BEHAVIOUR
//  - FSM IDLE -> HDR -> PAYLOAD -> IDLE; state, grant_idx, last_grant are registers.
//  - IDLE: if |s_hdr_valid, pick first requesting port after last_grant (wrapping at NUM_PORTS-1 -> 0);
//    register grant_idx, go HDR. No requests: stay IDLE. Exactly one idle cycle per arbitration.
//  - HDR: m_hdr_valid=s_hdr_valid[g]; m_dest_ip/m_src_port/m_dest_port = port g fields;
//    s_hdr_ready[g]=m_hdr_ready (combinational pass-through). On m_hdr_valid&m_hdr_ready -> PAYLOAD.
//    If the requester drops hdr_valid (protocol violation), stay in HDR; no timeout.
//  - PAYLOAD: m_tdata/m_tvalid/m_tlast = port g; s_tready[g]=m_tready. On m_tvalid&m_tready&m_tlast:
//    last_grant<=g, -> IDLE. Payload of granted port never forwarded before its header handshake.
//  - Non-granted ports: s_hdr_ready=0, s_tready=0 in every state. Header/payload of a port may be
//    presented together; payload waits.
//  - Latency: s_hdr_valid to m_hdr_valid = 1 cycle (IDLE arbitration); data path 0 cycles, no buffering.
//  - Outputs outside their phase forced to 0: m_hdr_* and header fields 0 unless HDR; m_t* 0 unless PAYLOAD.
//  - Reset (async, any state incl. mid-frame): state=IDLE, grant_idx=0, last_grant=NUM_PORTS-1 (port 0
//    wins first), busy=0, all m_* and s_*ready=0 immediately. Truncated frame is not completed.
//  - Single-byte frame (tvalid+tlast on first beat) legal: PAYLOAD lasts one accepted beat.
//  - Continuous single requester: frames back-to-back with one IDLE cycle between them.
// CONFIGURATION
//  UDP_TX_ARB_STATS_EN defined: extra output frame_cnt  out  NUM_PORTS*16  per-port count of completed
//    frames (tlast handshake), port p at [p*16+:16]; wraps 16'hFFFF->0; reset 0.
//  Not defined: port absent, no counters synthesised; behaviour otherwise identical.
// TESTING
//  1 Reset, port0 hdr_valid dest_ip=C0A80164 ports 1234/5678, 4-byte payload, m ready=1 -> m_hdr_valid
//    1 cycle after request with those fields; 4 bytes out, tlast on 4th; busy 0 after.
//  2 All 4 ports request simultaneously, 2-byte frames each -> grant order 0,1,2,3; then repeat -> 0,1,2,3.
//  3 Port 2 granted, m_tready toggles 1/0 each cycle on 6-byte frame -> bytes in order, no loss/dup;
//    s_tready[2] mirrors m_tready; s_tready of others 0 throughout.
//  4 Port 1 presents hdr+payload together, m_hdr_ready held 0 for 5 cycles -> m_tvalid stays 0 until
//    header accepted.
//  5 axis_rstn low mid-payload of port 3 -> same cycle m_tvalid=0, busy=0; after release, port 0 wins.
//  6 STATS_EN: 3 frames port 1, 1 frame port 0 -> frame_cnt[31:16]=3, [15:0]=1; preload 16'hFFFF -> wraps to 0.

Source files
------------

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP TX header + payload interface among NUM_PORTS requesters.
// Define UDP_TX_ARB_STATS_EN to add per-port completed-frame counters on output frame_cnt.

module udp_tx_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                    axis_clk,
    input  logic                    axis_rstn,
    input  logic [NUM_PORTS-1:0]    s_hdr_valid,
    output logic [NUM_PORTS-1:0]    s_hdr_ready,
    input  logic [NUM_PORTS*32-1:0] s_dest_ip,
    input  logic [NUM_PORTS*16-1:0] s_src_port,
    input  logic [NUM_PORTS*16-1:0] s_dest_port,
    input  logic [NUM_PORTS*8-1:0]  s_tdata,
    input  logic [NUM_PORTS-1:0]    s_tvalid,
    output logic [NUM_PORTS-1:0]    s_tready,
    input  logic [NUM_PORTS-1:0]    s_tlast,
    output logic                    m_hdr_valid,
    input  logic                    m_hdr_ready,
    output logic [31:0]             m_dest_ip,
    output logic [15:0]             m_src_port,
    output logic [15:0]             m_dest_port,
    output logic [7:0]              m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
`ifdef UDP_TX_ARB_STATS_EN
    output logic [NUM_PORTS*16-1:0] frame_cnt,
`endif
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    busy
);

    // state      | meaning
    // ST_IDLE    | no owner; pick next requester after last_grant
    // ST_HDR     | forward granted port's header until handshake
    // ST_PAYLOAD | forward granted port's payload until tlast handshake
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_nxt;
    logic [IDX_W-1:0] last_grant_nxt;
    logic [IDX_W-1:0] arb_pick;
    logic             arb_found;
    int               arb_best;
    int               arb_dist;

    logic             sel_hdr_valid;
    logic [31:0]      sel_dest_ip;
    logic [15:0]      sel_src_port;
    logic [15:0]      sel_dest_port;
    logic [7:0]       sel_tdata;
    logic             sel_tvalid;
    logic             sel_tlast;
    logic [NUM_PORTS-1:0] grant_dec;
    logic             frame_done;

    // Distance from last_grant decides priority: the port right after it wins.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        arb_best  = NUM_PORTS;
        arb_dist  = 0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            arb_dist = (p + NUM_PORTS - 1 - int'(last_grant)) % NUM_PORTS;
            if (s_hdr_valid[p] && (arb_dist < arb_best)) begin
                arb_best  = arb_dist;
                arb_pick  = IDX_W'(p);
                arb_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_hdr_valid = 1'b0;
        sel_dest_ip   = '0;
        sel_src_port  = '0;
        sel_dest_port = '0;
        sel_tdata     = '0;
        sel_tvalid    = 1'b0;
        sel_tlast     = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_idx == IDX_W'(p)) begin
                sel_hdr_valid = s_hdr_valid[p];
                sel_dest_ip   = s_dest_ip[p*32 +: 32];
                sel_src_port  = s_src_port[p*16 +: 16];
                sel_dest_port = s_dest_port[p*16 +: 16];
                sel_tdata     = s_tdata[p*8 +: 8];
                sel_tvalid    = s_tvalid[p];
                sel_tlast     = s_tlast[p];
            end
        end
    end

    assign grant_dec  = NUM_PORTS'(1) << grant_idx;
    assign frame_done = (state == ST_PAYLOAD) && sel_tvalid && m_tready && sel_tlast;

    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            state      <= ST_IDLE;
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state      <= state_nxt;
            grant_idx  <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Outputs are zero outside their phase; ready paths are pure pass-through.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_idx;
        last_grant_nxt = last_grant;
        m_hdr_valid    = 1'b0;
        m_dest_ip      = '0;
        m_src_port     = '0;
        m_dest_port    = '0;
        m_tdata        = '0;
        m_tvalid       = 1'b0;
        m_tlast        = 1'b0;
        s_hdr_ready    = '0;
        s_tready       = '0;
        case (state)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_nxt = arb_pick;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                m_hdr_valid = sel_hdr_valid;
                m_dest_ip   = sel_dest_ip;
                m_src_port  = sel_src_port;
                m_dest_port = sel_dest_port;
                s_hdr_ready = m_hdr_ready ? grant_dec : '0;
                if (sel_hdr_valid && m_hdr_ready) begin
                    state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                m_tdata  = sel_tdata;
                m_tvalid = sel_tvalid;
                m_tlast  = sel_tlast;
                s_tready = m_tready ? grant_dec : '0;
                if (frame_done) begin
                    last_grant_nxt = grant_idx;
                    state_nxt      = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

`ifdef UDP_TX_ARB_STATS_EN
    logic [15:0] frame_cnt_q [NUM_PORTS];

    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                frame_cnt_q[p] <= '0;
            end
        end else if (frame_done) begin
            frame_cnt_q[grant_idx] <= frame_cnt_q[grant_idx] + 16'd1;
        end
    end

    always_comb begin
        frame_cnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            frame_cnt[p*16 +: 16] = frame_cnt_q[p];
        end
    end
`endif

endmodule
